// File: rtl/rx_fifo_pkg.sv
// rtl/rx_fifo_pkg.sv - shared UART receive-path constants
package rx_fifo_pkg;

    localparam int UART_WIDTH          = 8;
    localparam int DEFAULT_DEPTH_LOG2  = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/rx_fifo_sync_rise.sv
// rtl/rx_fifo_sync_rise.sv - multi-flop synchroniser with registered rising-edge pulse
module rx_fifo_sync_rise #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;
    logic              rise_q;

    // Reset value propagates to last_q so a level already high at reset gives no pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            last_q <= RST_VAL;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            last_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~last_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - UART receive FIFO, first-word-fall-through with sticky overrun
module rx_fifo
    import rx_fifo_pkg::*;
#(
    parameter int WIDTH       = UART_WIDTH,
    parameter int DEPTH_LOG2  = DEFAULT_DEPTH_LOG2,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      rx_dat,
    input  logic                  rx_rdy,
    input  logic                  rx_d_rdy,
    output logic [WIDTH-1:0]      rd_dat,
    output logic                  rd_vld,
    input  logic                  rd_en,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  ovr,
    input  logic                  ovr_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2:0]    wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic                   ovr_q, ovr_d;
    logic [SYNC_STAGES-1:0] d_rdy_sync_q;
    logic                   rdy_rise;
    logic                   push, pop, do_write;

    rx_fifo_sync_rise #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_rdy_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (rx_rdy),
        .rise_o (rdy_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_rdy_sync_q <= '0;
        end else begin
            d_rdy_sync_q <= {d_rdy_sync_q[SYNC_STAGES-2:0], rx_d_rdy};
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                   (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
    assign count = wr_ptr_q - rd_ptr_q;

    // A frame with a bad stop bit still raises rx_rdy; only good frames push.
    assign push     = rdy_rise & d_rdy_sync_q[SYNC_STAGES-1];
    assign pop      = rd_en & ~empty;
    assign do_write = push & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovr_d    = ovr_q;
        if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
        if (ovr_clr)  ovr_d    = 1'b0;
        if (push & full & ~pop) ovr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovr_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovr_q    <= ovr_d;
            if (do_write) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= rx_dat;
        end
    end

    assign rd_dat = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign rd_vld = ~empty;
    assign ovr    = ovr_q;

endmodule
